bootstrap_ctrl: RTL

BOOTSTRAP_CTRL -- requirements
Module: bootstrap_ctrl

---
 rtl/bootstrap_pkg.sv | 8 +
 rtl/magic_matcher.sv | 28 ++
 rtl/bootstrap_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/bootstrap_pkg.sv
// bootstrap_pkg: shared state/error encodings and counter sizing for the bootstrap controller
package bootstrap_pkg;
  typedef enum logic [2:0] {LOCKED, LEN_HI, LEN_LO, PAYLOAD, DRAIN} state_e;
  typedef enum logic [1:0] {NONE = 2'd0, TIMEOUT = 2'd1, OVERFLOW = 2'd2, BAD_LEN = 2'd3} err_e;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/magic_matcher.sv
// magic_matcher: tracks progress through the unlock sequence and pulses on its final byte
module magic_matcher
  import bootstrap_pkg::*;
#(
  parameter int MAGIC_BYTES = 1,
  parameter logic [8*MAGIC_BYTES-1:0] MAGIC = '0
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  input  logic       clear_i,
  output logic       match_o
);
  localparam int CW = cw(MAGIC_BYTES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8*MAGIC_BYTES-1:0] sh;
  logic hit, last;
  // Shifting left by the counter brings byte [counter] (MSB first) to the top
  assign sh = MAGIC << (8 * cnt_q);
  assign hit = data_i == sh[8*MAGIC_BYTES-1 -: 8];
  assign last = cnt_q == CW'(MAGIC_BYTES - 1);
  assign match_o = valid_i && hit && last;
  assign cnt_d = clear_i ? '0 : !valid_i ? cnt_q : (hit && !last) ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk or posedge areset)
    if (areset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/bootstrap_ctrl.sv
// bootstrap_ctrl: magic-sequence unlock, length header capture and one-byte-buffered payload forwarding
module bootstrap_ctrl
  import bootstrap_pkg::*;
#(
  parameter int MAGIC_BYTES = 1,
  parameter logic [8*MAGIC_BYTES-1:0] MAGIC = '0,
  parameter int MAX_LEN = 256,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       s_axis_tvalid,
  input  logic [7:0] s_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tlast,
  output logic       unlocked,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);
  localparam int RW = cw(MAX_LEN + 1);
  localparam int TW = cw(TIMEOUT_CYCLES);
  state_e state_q;
  err_e code_q;
  logic [7:0] len_hi_q, hd_q;
  logic [RW-1:0] rem_q;
  logic [TW-1:0] tmo_q;
  logic [15:0] len;
  logic hv_q, hl_q, done_q, err_q, match, timed, drain, tmo_exp, bad_len, last_byte;

  magic_matcher #(.MAGIC_BYTES(MAGIC_BYTES), .MAGIC(MAGIC)) u_match (
    .clk(clk), .areset(areset), .valid_i(s_axis_tvalid && state_q == LOCKED),
    .data_i(s_axis_tdata), .clear_i(state_q != LOCKED), .match_o(match)
  );

  assign timed = state_q inside {LEN_HI, LEN_LO, PAYLOAD};
  assign drain = hv_q && m_axis_tready;
  assign tmo_exp = timed && !s_axis_tvalid && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  assign len = {len_hi_q, s_axis_tdata};
  assign bad_len = len == 16'd0 || {1'b0, len} > 17'(MAX_LEN);
  assign last_byte = rem_q == RW'(1);
  assign m_axis_tvalid = hv_q;
  assign m_axis_tdata = hd_q;
  assign m_axis_tlast = hl_q;
  assign unlocked = state_q != LOCKED;
  assign done = done_q;
  assign err = err_q;
  assign err_code = code_q;

  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      state_q <= LOCKED;
      code_q <= NONE;
      len_hi_q <= '0;
      hd_q <= '0;
      rem_q <= '0;
      tmo_q <= '0;
      hv_q <= 1'b0;
      hl_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= NONE;
      tmo_q <= (s_axis_tvalid || !timed || tmo_exp) ? '0 : tmo_q + 1'b1;
      if (drain) begin
        hv_q <= 1'b0;
        hl_q <= 1'b0;
      end
      if (tmo_exp) begin
        err_q <= 1'b1;
        code_q <= TIMEOUT;
        hv_q <= 1'b0;
        hl_q <= 1'b0;
        state_q <= LOCKED;
      end else
        case (state_q)
          LOCKED: if (match) state_q <= LEN_HI;
          LEN_HI: if (s_axis_tvalid) begin
            len_hi_q <= s_axis_tdata;
            state_q <= LEN_LO;
          end
          LEN_LO: if (s_axis_tvalid) begin
            if (bad_len) begin
              err_q <= 1'b1;
              code_q <= BAD_LEN;
              state_q <= LOCKED;
            end else begin
              rem_q <= RW'(len);
              state_q <= PAYLOAD;
            end
          end
          PAYLOAD: if (s_axis_tvalid) begin
            // A byte landing while the holder is full and stalled is an overrun
            if (hv_q && !m_axis_tready) begin
              err_q <= 1'b1;
              code_q <= OVERFLOW;
              hv_q <= 1'b0;
              hl_q <= 1'b0;
              state_q <= LOCKED;
            end else begin
              hd_q <= s_axis_tdata;
              hv_q <= 1'b1;
              hl_q <= last_byte;
              rem_q <= rem_q - 1'b1;
              if (last_byte) state_q <= DRAIN;
            end
          end
          DRAIN: if (drain) begin
            done_q <= 1'b1;
            state_q <= LOCKED;
          end
          default: state_q <= LOCKED;
        endcase
    end
endmodule
